// File: rtl/tile_loader_pkg.sv
// Shared types and constants for the tile stream loader.
package tile_loader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LAUNCH,
    WAIT_DONE
  } state_t;

  localparam logic [1:0] REGION_PROG = 2'b00;
  localparam logic [1:0] REGION_DATA = 2'b01;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_REGION  = 2'b01;
  localparam logic [1:0] ERR_RANGE   = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

endpackage

// File: rtl/tile_stream_loader.sv
// Streams a command's words into tile program/data memory over the mm port,
// then optionally starts the tile and waits for done with a timeout.
module tile_stream_loader
  import tile_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned TMO_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_region,
  input  logic [ADDR_WIDTH-3:0] cmd_base,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_launch,
  input  logic [TMO_WIDTH-1:0]  tmo_cycles,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  mm_valid,
  output logic                  mm_write,
  output logic [ADDR_WIDTH-1:0] mm_addr,
  output logic [DATA_WIDTH-1:0] mm_wdata,
  input  logic                  mm_ready,
  output logic                  tile_start,
  input  logic                  tile_done,
  output logic                  busy,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [LEN_WIDTH-1:0]  words_written
);

  localparam int unsigned OFF_W = ADDR_WIDTH - 2;
  localparam int unsigned SUM_W = ((OFF_W > LEN_WIDTH) ? OFF_W : LEN_WIDTH) + 1;
  localparam logic [SUM_W-1:0]     OFF_SPAN = SUM_W'(1) << OFF_W;
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);
  localparam logic [TMO_WIDTH-1:0] TMO_ONE  = TMO_WIDTH'(1);

  state_t state, state_next;

  logic [1:0]           region_q;
  logic [OFF_W-1:0]     base_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] idx;
  logic                 launch_q;
  logic [TMO_WIDTH-1:0] tmo_q;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 wait_armed;

  logic cmd_fire, in_fire, mm_fire;
  logic region_bad, range_bad, last_write, done_seen, tmo_hit;

  assign cmd_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign tile_start = (state == LAUNCH);
  assign mm_write   = mm_valid;
  assign in_ready   = (state == LOAD) && (idx != len_q) && (!mm_valid || mm_ready);

  assign cmd_fire   = cmd_valid && cmd_ready;
  assign in_fire    = in_valid && in_ready;
  assign mm_fire    = mm_valid && mm_ready;
  assign region_bad = (cmd_region != REGION_PROG) && (cmd_region != REGION_DATA);
  // Widened sum so base+len cannot wrap before the range compare.
  assign range_bad  = (SUM_W'(cmd_base) + SUM_W'(cmd_len)) > OFF_SPAN;
  assign last_write = mm_fire && (words_written == len_q - LEN_ONE);
  // The tile clears done one cycle late, so done is only trusted once armed.
  assign done_seen  = wait_armed && tile_done;
  assign tmo_hit    = (state == WAIT_DONE) && !done_seen && (tmo_q != '0)
                      && (tmo_cnt == tmo_q - TMO_ONE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_fire && !region_bad && !range_bad) begin
          if (cmd_len != '0)   state_next = LOAD;
          else if (cmd_launch) state_next = LAUNCH;
        end
      end
      LOAD: begin
        if (last_write) state_next = launch_q ? LAUNCH : IDLE;
      end
      LAUNCH: state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done_seen || tmo_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      region_q      <= '0;
      base_q        <= '0;
      len_q         <= '0;
      idx           <= '0;
      launch_q      <= 1'b0;
      tmo_q         <= '0;
      tmo_cnt       <= '0;
      wait_armed    <= 1'b0;
      mm_valid      <= 1'b0;
      mm_addr       <= '0;
      mm_wdata      <= '0;
      words_written <= '0;
      err           <= 1'b0;
      err_code      <= ERR_NONE;
    end else begin
      if (cmd_fire) begin
        region_q      <= cmd_region;
        base_q        <= cmd_base;
        len_q         <= cmd_len;
        launch_q      <= cmd_launch;
        tmo_q         <= tmo_cycles;
        idx           <= '0;
        words_written <= '0;
        err           <= region_bad || range_bad;
        err_code      <= region_bad ? ERR_REGION : (range_bad ? ERR_RANGE : ERR_NONE);
      end

      // Single-entry holding register: refill on stream accept, else drain on mm accept.
      if (in_fire) begin
        mm_valid <= 1'b1;
        mm_addr  <= {region_q, base_q + OFF_W'(idx)};
        mm_wdata <= in_data;
        idx      <= idx + LEN_ONE;
      end else if (mm_fire) begin
        mm_valid <= 1'b0;
      end

      if (mm_fire) words_written <= words_written + LEN_ONE;

      if (state == LAUNCH) begin
        tmo_cnt    <= '0;
        wait_armed <= 1'b0;
      end else if (state == WAIT_DONE) begin
        tmo_cnt    <= tmo_cnt + TMO_ONE;
        wait_armed <= 1'b1;
      end

      if (tmo_hit) begin
        err      <= 1'b1;
        err_code <= ERR_TIMEOUT;
      end
    end
  end

endmodule

// File: tb/tb_tile_stream_loader.sv
// Directed bench for tile_stream_loader with a tile mm_ready model and stream feeder.
module tb_tile_stream_loader;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LW = 12;
  localparam int TW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_region = '0;
  logic [AW-3:0] cmd_base = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_launch = 1'b0;
  logic [TW-1:0] tmo_cycles = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          mm_valid;
  logic          mm_write;
  logic [AW-1:0] mm_addr;
  logic [DW-1:0] mm_wdata;
  logic          mm_ready = 1'b0;
  logic          tile_start;
  logic          tile_done = 1'b0;
  logic          busy;
  logic          err;
  logic [1:0]    err_code;
  logic [LW-1:0] words_written;

  tile_stream_loader #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .LEN_WIDTH (LW),
    .TMO_WIDTH (TW)
  ) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_region(cmd_region),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .cmd_launch(cmd_launch),
    .tmo_cycles(tmo_cycles),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .mm_valid(mm_valid), .mm_write(mm_write), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_ready(mm_ready),
    .tile_start(tile_start), .tile_done(tile_done),
    .busy(busy), .err(err), .err_code(err_code), .words_written(words_written)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [DW-1:0] feed [0:15];
  int  feed_n = 0, feed_idx = 0;
  bit  feed_en = 1'b0;
  bit  cmd_pend = 1'b0;
  int  acc_cyc = 0;
  bit  prev_valid = 1'b0;
  int  stall_at = -1, stall_left = 0;
  int  done_delay = -1;

  logic [AW-1:0] wr_addr [0:31];
  logic [DW-1:0] wr_data [0:31];
  int  n_wr, n_mmv, n_start, start_cyc, err_cyc, bp_obs;
  bit  start_seen, err_seen, bp_bad;
  logic [AW-1:0] bp_addr;
  logic [DW-1:0] bp_data;

  task automatic clear_log();
    n_wr = 0; n_mmv = 0; n_start = 0; start_cyc = 0; err_cyc = 0; bp_obs = 0;
    start_seen = 1'b0; err_seen = 1'b0; bp_bad = 1'b0;
    stall_at = -1; stall_left = 0; done_delay = -1;
    feed_idx = 0; feed_n = 0; feed_en = 1'b0;
  endtask

  task automatic load_feed(input logic [DW-1:0] first, input int n);
    for (int i = 0; i < n; i++) feed[i] = first + DW'(i);
    feed_n = n; feed_idx = 0; feed_en = 1'b1;
  endtask

  // One clock cycle: drive at negedge, observe handshakes 1ns later, posedge follows.
  task automatic cycle();
    bit stalling;
    stalling = 1'b0;
    @(negedge clock);
    if (!reset) mm_ready = 1'b0;
    else if (stall_at >= 0 && n_wr == stall_at && stall_left > 0) begin
      mm_ready = 1'b0; stall_left--; stalling = 1'b1;
    end else mm_ready = mm_valid && prev_valid;
    prev_valid = mm_valid;
    in_valid  = feed_en && (feed_idx < feed_n);
    in_data   = in_valid ? feed[feed_idx] : '0;
    cmd_valid = cmd_pend;
    tile_done = (done_delay >= 0) && start_seen && (cyc >= start_cyc + done_delay);
    #1;
    if (cmd_valid && cmd_ready) begin cmd_pend = 1'b0; acc_cyc = cyc; end
    if (in_valid && in_ready) feed_idx++;
    if (mm_valid) begin
      n_mmv++;
      if (mm_ready && n_wr < 32) begin
        wr_addr[n_wr] = mm_addr; wr_data[n_wr] = mm_wdata; n_wr++;
      end
    end
    if (tile_start) begin
      n_start++;
      if (!start_seen) begin start_seen = 1'b1; start_cyc = cyc; end
    end
    if (err && !err_seen && !cmd_pend && cyc > acc_cyc) begin err_seen = 1'b1; err_cyc = cyc; end
    if (stalling) begin
      if (bp_obs == 0) begin bp_addr = mm_addr; bp_data = mm_wdata; end
      else if (mm_addr !== bp_addr || mm_wdata !== bp_data) bp_bad = 1'b1;
      if (in_ready || !mm_valid) bp_bad = 1'b1;
      bp_obs++;
    end
    cyc++;
  endtask

  task automatic run_cmd(input logic [1:0] region, input logic [AW-3:0] base,
                         input logic [LW-1:0] len, input logic launch,
                         input logic [TW-1:0] tmo, input int max_cyc,
                         output bit timed_out, output int exit_cyc);
    cmd_region = region; cmd_base = base; cmd_len = len;
    cmd_launch = launch; tmo_cycles = tmo; cmd_pend = 1'b1;
    timed_out = 1'b1; exit_cyc = -1;
    for (int i = 0; i < max_cyc; i++) begin
      cycle();
      if (!cmd_pend && (cyc - 1) > acc_cyc && !busy) begin
        timed_out = 1'b0; exit_cyc = cyc - 1; break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_vec++;
    if ({cmd_ready, in_ready, mm_valid, mm_write, tile_start, busy, err, err_code} !== 9'b1_0000_0000) begin
      n_bad++; $display("FAIL reset_flags: got %b expected %b",
        {cmd_ready, in_ready, mm_valid, mm_write, tile_start, busy, err, err_code}, 9'b1_0000_0000);
    end
    n_vec++;
    if ({mm_addr, mm_wdata, words_written} !== '0) begin
      n_bad++; $display("FAIL reset_regs: got %h/%h/%h expected 0", mm_addr, mm_wdata, words_written);
    end
    @(negedge clock); reset = 1'b1;
  endtask

  task automatic test_load_basic();
    bit to; int ex;
    clear_log();
    load_feed(32'hA0, 6);
    run_cmd(2'b01, 10'h010, 12'd4, 1'b0, 16'd0, 60, to, ex);
    n_vec++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %0d expected 0", to); end
    n_vec++; if (n_wr !== 4) begin n_bad++; $display("FAIL basic_nwr: got %0d expected 4", n_wr); end
    for (int i = 0; i < 4 && i < n_wr; i++) begin
      n_vec++;
      if (wr_addr[i] !== AW'(12'h410 + i) || wr_data[i] !== DW'(32'hA0 + i)) begin
        n_bad++; $display("FAIL basic_write%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i],
          AW'(12'h410 + i), DW'(32'hA0 + i));
      end
    end
    n_vec++; if (words_written !== 12'd4) begin n_bad++; $display("FAIL basic_ww: got %0d expected 4", words_written); end
    n_vec++; if (feed_idx !== 4) begin n_bad++; $display("FAIL basic_excess: consumed %0d expected 4", feed_idx); end
    n_vec++; if (n_start !== 0) begin n_bad++; $display("FAIL basic_start: got %0d expected 0", n_start); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err: got %b expected 0", err); end
    feed_en = 1'b0;
  endtask

  task automatic test_backpressure();
    bit to; int ex;
    clear_log();
    load_feed(32'hB0, 6);
    stall_at = 2; stall_left = 5;
    run_cmd(2'b00, 10'h020, 12'd6, 1'b0, 16'd0, 80, to, ex);
    n_vec++; if (to !== 1'b0) begin n_bad++; $display("FAIL bp_timeout: got %0d expected 0", to); end
    n_vec++; if (bp_obs !== 5) begin n_bad++; $display("FAIL bp_stall_cycles: got %0d expected 5", bp_obs); end
    n_vec++; if (bp_bad !== 1'b0) begin n_bad++; $display("FAIL bp_stable: got %b expected 0", bp_bad); end
    n_vec++; if (n_wr !== 6) begin n_bad++; $display("FAIL bp_nwr: got %0d expected 6", n_wr); end
    for (int i = 0; i < 6 && i < n_wr; i++) begin
      n_vec++;
      if (wr_addr[i] !== AW'(12'h020 + i) || wr_data[i] !== DW'(32'hB0 + i)) begin
        n_bad++; $display("FAIL bp_write%0d: got %h/%h expected %h/%h", i, wr_addr[i], wr_data[i],
          AW'(12'h020 + i), DW'(32'hB0 + i));
      end
    end
    n_vec++; if (words_written !== 12'd6) begin n_bad++; $display("FAIL bp_ww: got %0d expected 6", words_written); end
  endtask

  task automatic test_errors();
    bit to; int ex;
    clear_log();
    run_cmd(2'b10, 10'h000, 12'd4, 1'b0, 16'd0, 20, to, ex);
    n_vec++; if ({to, err, err_code} !== 4'b0_1_01) begin
      n_bad++; $display("FAIL region_err: got %b expected 0101", {to, err, err_code}); end
    n_vec++; if (n_mmv !== 0) begin n_bad++; $display("FAIL region_writes: got %0d expected 0", n_mmv); end

    clear_log();
    run_cmd(2'b00, 10'h3FE, 12'd3, 1'b0, 16'd0, 20, to, ex);
    n_vec++; if ({to, err, err_code} !== 4'b0_1_10) begin
      n_bad++; $display("FAIL range_err: got %b expected 0110", {to, err, err_code}); end
    n_vec++; if (n_mmv !== 0) begin n_bad++; $display("FAIL range_writes: got %0d expected 0", n_mmv); end

    clear_log();
    load_feed(32'hC0, 2);
    run_cmd(2'b00, 10'h3FE, 12'd2, 1'b0, 16'd0, 40, to, ex);
    n_vec++; if ({to, err, err_code} !== 4'b0_0_00) begin
      n_bad++; $display("FAIL range_edge_err: got %b expected 0000", {to, err, err_code}); end
    n_vec++;
    if (n_wr !== 2 || wr_addr[0] !== 12'h3FE || wr_addr[1] !== 12'h3FF
        || wr_data[0] !== 32'hC0 || wr_data[1] !== 32'hC1) begin
      n_bad++; $display("FAIL range_edge_writes: got n=%0d %h/%h %h/%h expected 2 3fe/c0 3ff/c1",
        n_wr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    feed_en = 1'b0;
  endtask

  task automatic test_launch();
    bit to; int ex;
    clear_log();
    done_delay = 7;
    run_cmd(2'b00, 10'h000, 12'd0, 1'b1, 16'd0, 40, to, ex);
    n_vec++; if (to !== 1'b0) begin n_bad++; $display("FAIL launch_timeout: got %0d expected 0", to); end
    n_vec++; if (n_start !== 1) begin n_bad++; $display("FAIL launch_pulses: got %0d expected 1", n_start); end
    n_vec++; if (start_cyc - acc_cyc !== 1) begin
      n_bad++; $display("FAIL launch_latency: got %0d expected 1", start_cyc - acc_cyc); end
    n_vec++; if (ex - start_cyc !== 8) begin
      n_bad++; $display("FAIL launch_done_exit: got %0d expected 8", ex - start_cyc); end
    n_vec++; if (err !== 1'b0) begin n_bad++; $display("FAIL launch_err: got %b expected 0", err); end

    clear_log();
    done_delay = 1;
    run_cmd(2'b00, 10'h000, 12'd0, 1'b1, 16'd0, 40, to, ex);
    n_vec++; if (to !== 1'b0 || ex - start_cyc !== 3) begin
      n_bad++; $display("FAIL early_done_ignored: got exit %0d expected 3", ex - start_cyc); end
  endtask

  task automatic test_timeout();
    bit to; int ex;
    clear_log();
    run_cmd(2'b01, 10'h000, 12'd0, 1'b1, 16'd8, 40, to, ex);
    n_vec++; if ({to, err, err_code} !== 4'b0_1_11) begin
      n_bad++; $display("FAIL tmo_err: got %b expected 0111", {to, err, err_code}); end
    n_vec++; if (err_cyc - start_cyc !== 9) begin
      n_bad++; $display("FAIL tmo_timing: got %0d expected 9", err_cyc - start_cyc); end

    clear_log();
    done_delay = 8;
    run_cmd(2'b01, 10'h000, 12'd0, 1'b1, 16'd8, 40, to, ex);
    n_vec++; if ({to, err, err_code} !== 4'b0_0_00) begin
      n_bad++; $display("FAIL tmo_done_wins: got %b expected 0000", {to, err, err_code}); end
    n_vec++; if (ex - start_cyc !== 9) begin
      n_bad++; $display("FAIL tmo_done_exit: got %0d expected 9", ex - start_cyc); end
  endtask

  task automatic test_reset_mid_load();
    bit to, seen; int ex;
    clear_log();
    load_feed(32'hD0, 8);
    cmd_region = 2'b01; cmd_base = 10'h100; cmd_len = 12'd8;
    cmd_launch = 1'b0; tmo_cycles = '0; cmd_pend = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      cycle();
      if (mm_valid) begin seen = 1'b1; break; end
    end
    n_vec++; if (seen !== 1'b1) begin n_bad++; $display("FAIL rst_mid_no_valid: got %b expected 1", seen); end
    reset = 1'b0;
    #1;
    n_vec++;
    if ({cmd_ready, in_ready, mm_valid, mm_write, tile_start, busy, err, err_code} !== 9'b1_0000_0000) begin
      n_bad++; $display("FAIL rst_mid_flags: got %b expected %b",
        {cmd_ready, in_ready, mm_valid, mm_write, tile_start, busy, err, err_code}, 9'b1_0000_0000);
    end
    n_vec++;
    if ({mm_addr, mm_wdata, words_written} !== '0) begin
      n_bad++; $display("FAIL rst_mid_regs: got %h/%h/%h expected 0", mm_addr, mm_wdata, words_written);
    end
    feed_en = 1'b0; cmd_pend = 1'b0;
    cycle(); cycle();
    reset = 1'b1;

    clear_log();
    load_feed(32'hE0, 2);
    done_delay = 2;
    run_cmd(2'b01, 10'h000, 12'd2, 1'b1, 16'd0, 60, to, ex);
    n_vec++; if ({to, err} !== 2'b00) begin n_bad++; $display("FAIL rst_fresh_status: got %b expected 00", {to, err}); end
    n_vec++;
    if (n_wr !== 2 || wr_addr[0] !== 12'h400 || wr_addr[1] !== 12'h401
        || wr_data[0] !== 32'hE0 || wr_data[1] !== 32'hE1) begin
      n_bad++; $display("FAIL rst_fresh_writes: got n=%0d %h/%h %h/%h expected 2 400/e0 401/e1",
        n_wr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    n_vec++; if (n_start !== 1 || words_written !== 12'd2) begin
      n_bad++; $display("FAIL rst_fresh_launch: got start=%0d ww=%0d expected 1/2", n_start, words_written); end
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_backpressure();
    test_errors();
    test_launch();
    test_timeout();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tile_stream_loader.md
Name: tile_stream_loader

Overview:
- Upstream feeder for one processing tile: takes a load command plus a word stream and writes the words into tile program or data memory over the tile memory-mapped port.
- Optionally pulses tile start afterwards, then waits for tile done with a timeout.
- Sits between the array-level DMA/host stream and each tile's mm_*/start/done pins.

Parameters:
DATA_WIDTH, 32, data word width (matches tile)
ADDR_WIDTH, 12, tile mm address width; top 2 bits are the region, low ADDR_WIDTH-2 bits are the offset
LEN_WIDTH, 12, command length field width (words)
TMO_WIDTH, 16, done-timeout counter width

Ports:
clock  in  1  single clock; all state on posedge
reset  in  1  asynchronous, active-low reset (asserted when 0)
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when cmd_valid&&cmd_ready
cmd_region  in  2  00 program mem, 01 data mem, 10/11 illegal
cmd_base  in  ADDR_WIDTH-2  first word offset
cmd_len  in  LEN_WIDTH  word count; 0 is legal
cmd_launch  in  1  pulse tile_start after load
tmo_cycles  in  TMO_WIDTH  done timeout; 0 disables timeout
in_valid  in  1  stream word valid
in_data  in  DATA_WIDTH  stream word
in_ready  out  1  stream word consumed when in_valid&&in_ready
mm_valid  out  1  write request to tile
mm_write  out  1  always 1 while mm_valid
mm_addr  out  ADDR_WIDTH  {region, offset}
mm_wdata  out  DATA_WIDTH  write data
mm_ready  in  1  tile accepts when mm_valid&&mm_ready
tile_start  out  1  one-cycle start pulse
tile_done  in  1  tile completion
busy  out  1  state != IDLE
err  out  1  sticky error flag
err_code  out  2  01 illegal region, 10 range overflow, 11 timeout
words_written  out  LEN_WIDTH  mm writes accepted for the current command

Behaviour:
- Reset values: cmd_ready=1, in_ready=0, mm_valid=0, mm_write=0, mm_addr=0, mm_wdata=0, tile_start=0, busy=0, err=0, err_code=0, words_written=0, state=IDLE.
- Reset mid-operation: any in-flight write is dropped and all outputs return to reset values immediately.
- FSM states: IDLE, LOAD, LAUNCH, WAIT_DONE.
- IDLE: cmd_ready=1. On accept, latch region/base/len/launch/tmo, clear err, err_code and words_written. Then check:
  - region is 1x: set err, err_code=01, stay IDLE, no writes.
  - base+len > 2^(ADDR_WIDTH-2), computed at full width with no wrap: set err, err_code=10, stay IDLE.
  - len=0: go to LAUNCH if launch, else stay IDLE.
  - otherwise go to LOAD.
  - cmd_ready=0 in every state other than IDLE.
- LOAD uses a single output holding register, one entry, feeding mm_*:
  - in_ready = (state==LOAD) && (remaining_to_fetch>0) && (!mm_valid || mm_ready).
  - On stream accept: mm_valid=1 next cycle, mm_addr={region, base+idx}, mm_wdata=in_data, idx increments.
  - mm_addr and mm_wdata are held stable while mm_valid && !mm_ready.
  - On mm accept: words_written++. The register refills in the same cycle if a stream word is accepted; otherwise mm_valid drops.
  - Steady-state throughput is 1 word/cycle when the tile's mm_ready stays high. The tile asserts mm_ready one cycle after it first sees mm_valid, so first-write latency is 2 cycles from in_valid.
  - When words_written reaches len on an mm accept: go to LAUNCH if launch, else IDLE. mm_valid=0 in that next cycle.
  - Excess in_valid beyond len is not consumed (in_ready=0).
- LAUNCH: tile_start=1 for exactly one cycle, then go to WAIT_DONE with the timeout counter at 0.
- WAIT_DONE:
  - tile_done is ignored in the first cycle after the start pulse, because the tile clears done one cycle late. From the second cycle onward, tile_done=1 moves the FSM to IDLE.
  - Timeout counter increments each cycle. If tmo_cycles!=0 and counter==tmo_cycles-1 without done, set err, err_code=11, go to IDLE.
  - If done and timeout occur in the same cycle, done wins: no error.
- err and err_code remain set until the next command accept.

Decomposition:
- Package tile_loader_pkg holds:
  - the state enum;
  - region constants REGION_PROG=2'b00 and REGION_DATA=2'b01;
  - error code constants ERR_NONE, ERR_REGION, ERR_RANGE, ERR_TIMEOUT.
- No sub-module is needed; the holding register is inline.

Test Plan:
- cmd region=01 base=0x010 len=4 launch=0, stream 0xA0..0xA3, tile_ready model follows tile timing -> 4 writes at mm_addr 0x410..0x413 with matching data, words_written=4, busy falls, no tile_start.
- Backpressure: mm_ready held 0 for 5 cycles mid-burst -> mm_addr/mm_wdata stable, in_ready=0, no word lost or duplicated.
- region=10 -> err=1, err_code=01, zero mm_valid cycles. base=0x3FE len=3 -> err_code=10, no writes. base=0x3FE len=2 -> accepted, writes to 0x3FE and 0x3FF.
- len=0 launch=1 -> tile_start pulse 1 cycle after accept. tile_done asserted 7 cycles later -> IDLE, err=0.
- launch=1 tmo=8, tile_done never asserted -> err_code=11 exactly 8 cycles after entering WAIT_DONE. Repeat with done on the same cycle as timeout -> no error.
- reset driven low while in LOAD with mm_valid=1 -> all outputs at reset values immediately. After release, a fresh command runs normally.
